// File: rtl/blk_b16cad.sv
// Packs 2-bit direct-control-transfer trace codes into 15-code frames behind a one-deep output slot.
// Optional macro DCT_DROP_COUNTER_EN adds the drop_cnt output (saturating count of codes dropped in STALL).
module blk_b16cad #(
   parameter bit FLUSH_ON_TRC_OFF = 1'b1
) (
   input  logic        clk,
   input  logic        jrst_n,
   input  logic        trc_on,
   input  logic        dct_valid,
   input  logic [1:0]  dct_code,
   input  logic        flush,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [33:0] frame_data,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        ovf,
   input  logic        ovf_clr
`ifdef DCT_DROP_COUNTER_EN
   ,
   output logic [7:0]  drop_cnt
`endif
);

   localparam int unsigned CODE_W = 2;
   localparam int unsigned BUF_W  = 30;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DROP_W = 8;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [BUF_W-1:0] buffer;
   } frame_t;

   typedef enum logic [1:0] {EMPTY, FILL, STALL} state_e;

   state_e             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   frame_t             frame_q, frame_d;
   logic               frame_valid_q, frame_valid_d;
   logic               ovf_q, ovf_d;
   logic               trc_q, trc_d;

   logic               slot_free;
   logic               accept;
   logic               flush_req;
   logic               drop;
   logic               emit_req;
   logic [BUF_W-1:0]   nxt_buf;
   logic [CNT_W-1:0]   nxt_cnt;

   assign slot_free = !frame_valid_q || frame_ready;
   assign accept    = trc_on && dct_valid;
   assign flush_req = flush || (FLUSH_ON_TRC_OFF && trc_q && !trc_on);
   assign drop      = (state_q == STALL) && accept;
   assign nxt_buf   = accept ? {buf_q[BUF_W-CODE_W-1:0], dct_code} : buf_q;
   assign nxt_cnt   = cnt_q + CNT_W'(accept);
   // A frame is due when the 15th code lands or a flush finds anything to send.
   assign emit_req  = (accept && (cnt_q == CNT_W'(14))) ||
                      (flush_req && (nxt_cnt != '0));

   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      cnt_d         = cnt_q;
      frame_d       = frame_q;
      frame_valid_d = frame_valid_q && !frame_ready;
      ovf_d         = ovf_q;
      trc_d         = trc_on;

      case (state_q)
         STALL: begin
            if (slot_free) begin
               frame_d       = '{count: cnt_q, buffer: buf_q};
               frame_valid_d = 1'b1;
               buf_d         = '0;
               cnt_d         = '0;
               state_d       = EMPTY;
            end
         end
         default: begin
            if (emit_req && slot_free) begin
               frame_d       = '{count: nxt_cnt, buffer: nxt_buf};
               frame_valid_d = 1'b1;
               buf_d         = '0;
               cnt_d         = '0;
               state_d       = EMPTY;
            end else begin
               buf_d   = nxt_buf;
               cnt_d   = nxt_cnt;
               if (emit_req)
                  state_d = STALL;
               else if (nxt_cnt == '0)
                  state_d = EMPTY;
               else
                  state_d = FILL;
            end
         end
      endcase

      // A same-cycle drop wins over the clear.
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge jrst_n) begin
      if (!jrst_n) begin
         state_q       <= EMPTY;
         buf_q         <= '0;
         cnt_q         <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
         trc_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         cnt_q         <= cnt_d;
         frame_q       <= frame_d;
         frame_valid_q <= frame_valid_d;
         ovf_q         <= ovf_d;
         trc_q         <= trc_d;
      end
   end

   assign frame_valid = frame_valid_q;
   assign frame_data  = frame_q;
   assign dct_buffer  = buf_q;
   assign dct_count   = cnt_q;
   assign ovf         = ovf_q;

`ifdef DCT_DROP_COUNTER_EN
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = ovf_clr ? '0 : drop_cnt_q;
      if (drop && (drop_cnt_d != '1))
         drop_cnt_d = drop_cnt_d + DROP_W'(1);
   end

   always_ff @(posedge clk or negedge jrst_n) begin
      if (!jrst_n) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   localparam int unsigned DROP_UNUSED_W = DROP_W;
`endif

endmodule

// File: tb/tb_blk_b16cad.sv
// Directed bench for blk_b16cad: full frames, flushes, stall/overflow, trc_on-off flush and reset.
module tb_blk_b16cad;

   logic        clk = 1'b0;
   logic        jrst_n, trc_on, dct_valid, flush, frame_ready, ovf_clr;
   logic [1:0]  dct_code;
   logic        frame_valid, ovf, frame_valid0, ovf0;
   logic [33:0] frame_data, frame_data0;
   logic [29:0] dct_buffer, dct_buffer0;
   logic [3:0]  dct_count, dct_count0;
`ifdef DCT_DROP_COUNTER_EN
   logic [7:0]  drop_cnt, drop_cnt0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   blk_b16cad u_dut (
      .clk(clk), .jrst_n(jrst_n), .trc_on(trc_on), .dct_valid(dct_valid),
      .dct_code(dct_code), .flush(flush), .frame_ready(frame_ready),
      .frame_valid(frame_valid), .frame_data(frame_data), .dct_buffer(dct_buffer),
      .dct_count(dct_count), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef DCT_DROP_COUNTER_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   blk_b16cad #(.FLUSH_ON_TRC_OFF(1'b0)) u_dut0 (
      .clk(clk), .jrst_n(jrst_n), .trc_on(trc_on), .dct_valid(dct_valid),
      .dct_code(dct_code), .flush(flush), .frame_ready(frame_ready),
      .frame_valid(frame_valid0), .frame_data(frame_data0), .dct_buffer(dct_buffer0),
      .dct_count(dct_count0), .ovf(ovf0), .ovf_clr(ovf_clr)
`ifdef DCT_DROP_COUNTER_EN
      , .drop_cnt(drop_cnt0)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] code);
      dct_valid = 1'b1;
      dct_code  = code;
      step();
      dct_valid = 1'b0;
   endtask

   task automatic test_reset();
      jrst_n = 1'b1; trc_on = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
      flush = 1'b0; frame_ready = 1'b0; ovf_clr = 1'b0;
      #2 jrst_n = 1'b0;
      step(); step();
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
      n_checks++;
      if (frame_data !== 34'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", frame_data); end
      @(negedge clk) jrst_n = 1'b1;
      step();
      n_checks++;
      if ({dct_count, dct_buffer, ovf} !== 35'h0) begin
         n_fail++; $display("FAIL reset_state: cnt %h buf %h ovf %b want all 0", dct_count, dct_buffer, ovf);
      end
   endtask

   task automatic test_full_frame();
      trc_on = 1'b1; frame_ready = 1'b1;
      for (int i = 0; i < 14; i++) send(2'b01);
      n_checks++;
      if (dct_count !== 4'd14 || dct_buffer !== 30'h05555555 || frame_valid !== 1'b0) begin
         n_fail++; $display("FAIL full_14: cnt %0d buf %h valid %b want 14 05555555 0", dct_count, dct_buffer, frame_valid);
      end
      send(2'b01);
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== {4'hF, 30'h15555555}) begin
         n_fail++; $display("FAIL full_frame: valid %b data %h want 1 %h", frame_valid, frame_data, {4'hF, 30'h15555555});
      end
      n_checks++;
      if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
         n_fail++; $display("FAIL full_clear: cnt %0d buf %h want 0 0", dct_count, dct_buffer);
      end
      step();
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop: valid %b want 0", frame_valid); end
   endtask

   task automatic test_flush();
      send(2'd3); send(2'd2); send(2'd1);
      flush = 1'b1; step(); flush = 1'b0;
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== {4'd3, 30'h39}) begin
         n_fail++; $display("FAIL flush_frame: valid %b data %h want 1 %h", frame_valid, frame_data, {4'd3, 30'h39});
      end
      step();
      n_checks++;
      if (frame_valid !== 1'b0 || dct_count !== 4'd0) begin
         n_fail++; $display("FAIL flush_one_cycle: valid %b cnt %0d want 0 0", frame_valid, dct_count);
      end
      flush = 1'b1; step(); flush = 1'b0;
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: valid %b want 0", frame_valid); end
   endtask

   task automatic test_flush_same_cycle();
      send(2'd1); send(2'd3);
      flush = 1'b1; send(2'b10); flush = 1'b0;
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== {4'd3, 30'h1E}) begin
         n_fail++; $display("FAIL flush_same: valid %b data %h want 1 %h", frame_valid, frame_data, {4'd3, 30'h1E});
      end
      step();
   endtask

   task automatic test_stall_ovf();
      frame_ready = 1'b0;
      send(2'd3);
      flush = 1'b1; step(); flush = 1'b0;
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== {4'd1, 30'h3}) begin
         n_fail++; $display("FAIL stall_first: valid %b data %h want 1 %h", frame_valid, frame_data, {4'd1, 30'h3});
      end
      for (int i = 0; i < 15; i++) send(2'b10);
      n_checks++;
      if (dct_count !== 4'd15 || frame_data !== {4'd1, 30'h3} || ovf !== 1'b0) begin
         n_fail++; $display("FAIL stall_enter: cnt %0d data %h ovf %b want 15 %h 0", dct_count, frame_data, ovf, {4'd1, 30'h3});
      end
      for (int i = 0; i < 5; i++) send(2'b01);
      n_checks++;
      if (ovf !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA) begin
         n_fail++; $display("FAIL stall_drop: ovf %b cnt %0d buf %h want 1 15 2aaaaaaa", ovf, dct_count, dct_buffer);
      end
`ifdef DCT_DROP_COUNTER_EN
      n_checks++;
      if (drop_cnt !== 8'd5) begin n_fail++; $display("FAIL drop_cnt: got %0d want 5", drop_cnt); end
`endif
      frame_ready = 1'b1; step();
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== {4'hF, 30'h2AAAAAAA} || dct_count !== 4'd0) begin
         n_fail++; $display("FAIL stall_release: valid %b data %h cnt %0d want 1 %h 0", frame_valid, frame_data, dct_count, {4'hF, 30'h2AAAAAAA});
      end
      step();
      n_checks++;
      if (frame_valid !== 1'b0 || ovf !== 1'b1) begin
         n_fail++; $display("FAIL stall_after: valid %b ovf %b want 0 1", frame_valid, ovf);
      end
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      n_checks++;
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf); end
   endtask

   task automatic test_trc_off();
      send(2'd0); send(2'd1); send(2'd2); send(2'd3);
      trc_on = 1'b0; step();
      n_checks++;
      if (frame_valid !== 1'b1 || frame_data !== {4'd4, 30'h1B} || dct_count !== 4'd0) begin
         n_fail++; $display("FAIL trc_flush: valid %b data %h cnt %0d want 1 %h 0", frame_valid, frame_data, dct_count, {4'd4, 30'h1B});
      end
      n_checks++;
      if (frame_valid0 !== 1'b0 || dct_count0 !== 4'd4) begin
         n_fail++; $display("FAIL trc_noflush: valid %b cnt %0d want 0 4", frame_valid0, dct_count0);
      end
      send(2'd1);
      n_checks++;
      if (dct_count !== 4'd0 || dct_count0 !== 4'd4) begin
         n_fail++; $display("FAIL trc_ignore: cnt %0d cnt0 %0d want 0 4", dct_count, dct_count0);
      end
      trc_on = 1'b1;
   endtask

   task automatic test_reset_mid();
      frame_ready = 1'b0;
      send(2'd1);
      flush = 1'b1; step(); flush = 1'b0;
      for (int i = 0; i < 7; i++) send(2'd3);
      n_checks++;
      if (frame_valid !== 1'b1 || dct_count !== 4'd7) begin
         n_fail++; $display("FAIL mid_setup: valid %b cnt %0d want 1 7", frame_valid, dct_count);
      end
      jrst_n = 1'b0; #1;
      n_checks++;
      if ({frame_valid, frame_data, dct_buffer, dct_count, ovf} !== 70'h0) begin
         n_fail++; $display("FAIL mid_reset: valid %b data %h buf %h cnt %0d ovf %b want all 0", frame_valid, frame_data, dct_buffer, dct_count, ovf);
      end
      step();
      @(negedge clk) jrst_n = 1'b1;
      frame_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (frame_valid !== 1'b0 || dct_count !== 4'd0) begin
            n_fail++; $display("FAIL mid_release: cycle %0d valid %b cnt %0d want 0 0", i, frame_valid, dct_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_flush();
      test_flush_same_cycle();
      test_stall_ovf();
      test_trc_off();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
